// File: rtl/pkt_pkg.sv
// pkt_pkg: shared states, error codes, defaults and checksum helper for the packet framing stage
package pkt_pkg;
   typedef enum logic [1:0] {IDLE, PAYLOAD, CSUM, REPORT} state_e;
   typedef enum logic [1:0] {ERR_NONE = 2'd0, ERR_LEN = 2'd1, ERR_CSUM = 2'd2, ERR_TMO = 2'd3} err_e;
   localparam int DEF_MAX_LEN = 16;
   localparam int DEF_TIMEOUT = 8;
   function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: counter that sticks at all-ones instead of wrapping
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (inc && cnt != '1) cnt <= cnt + CNT_W'(1);
endmodule

// File: rtl/pkt_frame_checker.sv
// pkt_frame_checker: frames length/payload/checksum byte stream, forwards payload, reports verdicts
module pkt_frame_checker
   import pkt_pkg::*;
#(
   parameter int MAX_LEN = DEF_MAX_LEN,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [7:0]       out_data,
   output logic             out_last,
   output logic             pkt_done,
   output logic             pkt_good,
   output logic [1:0]       pkt_err,
   output logic [CNT_W-1:0] good_cnt,
   output logic [CNT_W-1:0] bad_cnt
);
   localparam int TW = $clog2(TIMEOUT + 1);
   state_e        state, state_d;
   err_e          err_d;
   logic [7:0]    remaining, remaining_d, xsum, xsum_d;
   logic [TW-1:0] timer, timer_d;
   logic          alive, acc, fwd, tmo;
   // alive keeps in_ready low until the first clock after reset release
   assign in_ready = alive && state != REPORT;
   assign acc = in_valid && in_ready;
   assign fwd = acc && state == PAYLOAD;
   assign tmo = timer == TW'(TIMEOUT - 1);
   always_comb begin
      state_d = state;
      err_d = ERR_NONE;
      remaining_d = remaining;
      xsum_d = xsum;
      timer_d = timer;
      case (state)
         IDLE:
            if (acc) begin
               if (in_data == 8'd0 || in_data > 8'(MAX_LEN)) begin
                  state_d = REPORT;
                  err_d = ERR_LEN;
               end else begin
                  state_d = PAYLOAD;
                  remaining_d = in_data;
                  xsum_d = 8'd0;
                  timer_d = '0;
               end
            end
         PAYLOAD:
            if (acc) begin
               xsum_d = csum_step(xsum, in_data);
               remaining_d = remaining - 8'd1;
               timer_d = '0;
               state_d = (remaining == 8'd1) ? CSUM : PAYLOAD;
            end else begin
               timer_d = timer + TW'(1);
               state_d = tmo ? REPORT : PAYLOAD;
               err_d = tmo ? ERR_TMO : ERR_NONE;
            end
         CSUM:
            if (acc) begin
               timer_d = '0;
               state_d = REPORT;
               err_d = (in_data == xsum) ? ERR_NONE : ERR_CSUM;
            end else begin
               timer_d = timer + TW'(1);
               state_d = tmo ? REPORT : CSUM;
               err_d = tmo ? ERR_TMO : ERR_NONE;
            end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         remaining <= 8'd0;
         xsum <= 8'd0;
         timer <= '0;
         alive <= 1'b0;
         out_valid <= 1'b0;
         out_data <= 8'd0;
         out_last <= 1'b0;
         pkt_done <= 1'b0;
         pkt_good <= 1'b0;
         pkt_err <= 2'd0;
      end else begin
         state <= state_d;
         remaining <= remaining_d;
         xsum <= xsum_d;
         timer <= timer_d;
         alive <= 1'b1;
         out_valid <= fwd;
         out_data <= fwd ? in_data : out_data;
         out_last <= fwd && remaining == 8'd1;
         pkt_done <= state_d == REPORT;
         pkt_good <= state_d == REPORT && err_d == ERR_NONE;
         pkt_err <= (state_d == REPORT) ? err_d : ERR_NONE;
      end
   sat_counter #(.CNT_W(CNT_W)) u_good (.clk(clk), .rst_n(rst_n), .inc(pkt_done && pkt_good), .cnt(good_cnt));
   sat_counter #(.CNT_W(CNT_W)) u_bad (.clk(clk), .rst_n(rst_n), .inc(pkt_done && !pkt_good), .cnt(bad_cnt));
endmodule

// File: tb/tb_pkt_frame_checker.sv
// tb_pkt_frame_checker: directed packets with a packet-level reference model checked every cycle
module tb_pkt_frame_checker;
   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'd0;
   logic       in_ready, out_valid, out_last, pkt_done, pkt_good;
   logic [7:0] out_data, good_cnt, bad_cnt;
   logic [1:0] pkt_err;
   int checks = 0, failures = 0;
   pkt_frame_checker #(.MAX_LEN(16), .TIMEOUT(8), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .pkt_done(pkt_done),
      .pkt_good(pkt_good), .pkt_err(pkt_err), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic logic [7:0] xor_of(input logic [7:0] q[$]);
      logic [7:0] x = 8'd0;
      foreach (q[i]) x = x ^ q[i];
      return x;
   endfunction
   // reference model: expected outputs for the cycle following each clock edge
   int e_rdy = 0, e_ov = 0, e_od = 0, e_ol = 0, e_done = 0, e_good = 0, e_err = 0, e_gc = 0, e_bc = 0;
   int len = 0, idle = 0, rep_err = 0;
   bit in_rep = 0, alive = 0, accepted;
   logic [7:0] pay[$];
   task automatic report(input int e);
      e_done = 1;
      e_good = (e == 0);
      e_err = e;
      rep_err = e;
      in_rep = 1;
      e_rdy = 0;
      len = 0;
   endtask
   task automatic tick();
      idle++;
      if (idle == 8) report(3);
   endtask
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {e_rdy, e_ov, e_od, e_ol, e_done, e_good, e_err, e_gc, e_bc} = '0;
         len = 0; idle = 0; in_rep = 0; alive = 0;
         pay.delete();
      end else begin
         accepted = in_valid && e_rdy != 0;
         e_ov = 0; e_ol = 0; e_done = 0; e_good = 0; e_err = 0;
         if (!alive) begin
            alive = 1;
            e_rdy = 1;
         end else if (in_rep) begin
            in_rep = 0;
            e_rdy = 1;
            if (rep_err == 0) e_gc = (e_gc == 255) ? 255 : e_gc + 1;
            else e_bc = (e_bc == 255) ? 255 : e_bc + 1;
         end else if (len == 0) begin
            if (accepted) begin
               if (in_data == 0 || in_data > 16) report(1);
               else begin
                  len = in_data;
                  pay.delete();
                  idle = 0;
               end
            end
         end else if (pay.size() < len) begin
            if (accepted) begin
               pay.push_back(in_data);
               e_ov = 1;
               e_od = in_data;
               e_ol = (pay.size() == len);
               idle = 0;
            end else tick();
         end else begin
            if (accepted) report(in_data == xor_of(pay) ? 0 : 2);
            else tick();
         end
      end
   end
   logic [7:0] obs[$];
   int obs_last = 0, done_cnt = 0, last_err = 0, last_good = 0, low_rdy = 0;
   always @(negedge clk) begin
      chk("in_ready", in_ready, e_rdy);
      chk("out_valid", out_valid, e_ov);
      if (e_ov != 0) chk("out_data", out_data, e_od);
      chk("out_last", out_last, e_ol);
      chk("pkt_done", pkt_done, e_done);
      chk("pkt_good", pkt_good, e_good);
      chk("pkt_err", pkt_err, e_err);
      chk("good_cnt", good_cnt, e_gc);
      chk("bad_cnt", bad_cnt, e_bc);
      if (out_valid) obs.push_back(out_data);
      if (out_last) obs_last++;
      if (pkt_done) begin
         done_cnt++;
         last_err = pkt_err;
         last_good = pkt_good;
      end
      if (rst_n && !in_ready) low_rdy++;
   end
   task automatic send(input logic [7:0] b);
      in_valid = 1'b1;
      in_data = b;
      @(negedge clk);
   endtask
   task automatic gap(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask
   task automatic clear_obs();
      obs.delete();
      obs_last = 0; done_cnt = 0; last_err = 0; last_good = 0; low_rdy = 0;
   endtask
   task automatic do_reset();
      in_valid = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      clear_obs();
   endtask
   initial begin
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_pkt_done", pkt_done, 0);
      chk("rst_good_cnt", good_cnt, 0);
      chk("rst_bad_cnt", bad_cnt, 0);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("rdy_after_release", in_ready, 1);
      clear_obs();
      send(8'd3); send(8'h11); send(8'h22); send(8'h44); send(8'h77); gap(2);
      chk("t1_nbytes", obs.size(), 3);
      if (obs.size() == 3) begin
         chk("t1_b0", obs[0], 8'h11);
         chk("t1_b1", obs[1], 8'h22);
         chk("t1_b2", obs[2], 8'h44);
      end
      chk("t1_last", obs_last, 1);
      chk("t1_done", done_cnt, 1);
      chk("t1_good", last_good, 1);
      chk("t1_err", last_err, 0);
      chk("t1_good_cnt", good_cnt, 1);
      clear_obs();
      send(8'd3); send(8'h11); send(8'h22); send(8'h44); send(8'h70); gap(2);
      chk("t2_nbytes", obs.size(), 3);
      chk("t2_good", last_good, 0);
      chk("t2_err", last_err, 2);
      chk("t2_bad_cnt", bad_cnt, 1);
      chk("t2_good_cnt", good_cnt, 1);
      do_reset();
      send(8'h00); gap(1); send(8'h11); gap(2);
      chk("t3_done", done_cnt, 2);
      chk("t3_err", last_err, 1);
      chk("t3_nbytes", obs.size(), 0);
      chk("t3_bad_cnt", bad_cnt, 2);
      do_reset();
      send(8'd2); send(8'hAA); gap(9);
      chk("t4_done", done_cnt, 1);
      chk("t4_err", last_err, 3);
      chk("t4_last", obs_last, 0);
      chk("t4_nbytes", obs.size(), 1);
      chk("t4_bad_cnt", bad_cnt, 1);
      chk("t4_idle_ready", in_ready, 1);
      send(8'd1); send(8'h5A); send(8'h5A); gap(2);
      chk("t4_next_err", last_err, 0);
      chk("t4_good_cnt", good_cnt, 1);
      do_reset();
      for (int i = 0; i < 256; i++) begin
         send(8'd1); send(8'(i)); send(8'(i)); gap(1);
      end
      gap(1);
      chk("t5_good_cnt", good_cnt, 255);
      chk("t5_done", done_cnt, 256);
      chk("t5_low_rdy", low_rdy, 256);
      chk("t5_bad_cnt", bad_cnt, 0);
      do_reset();
      send(8'd4); send(8'h01); send(8'h02);
      #2 rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("t6_out_valid", out_valid, 0);
      chk("t6_out_data", out_data, 0);
      chk("t6_in_ready", in_ready, 0);
      chk("t6_pkt_done", pkt_done, 0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      clear_obs();
      send(8'd2); send(8'h3C); send(8'hC3); send(8'hFF); gap(2);
      chk("t6_done", done_cnt, 1);
      chk("t6_good", last_good, 1);
      chk("t6_good_cnt", good_cnt, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog: simulation did not complete");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pkt_frame_checker.md
Name: pkt_frame_checker

Overview:
Synthesizable receive-side stage that consumes the 8-bit packet byte stream produced by the packet generator/driver, one byte per valid cycle. It frames each packet as a length byte, then payload bytes, then a checksum byte. It forwards payload bytes downstream and reports each packet as good or bad with an error code. Saturating good/bad counters give the bench and the scoreboard a cheap pass/fail summary when corrupted (bad) packets are injected.

Parameters:
MAX_LEN, 16, maximum legal payload length in bytes (1..255).
TIMEOUT, 8, idle cycles allowed between bytes inside a packet before abort.
CNT_W, 8, width of the good/bad packet counters.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  in_data carries a byte this cycle.
in_data  input  8  stream byte.
in_ready  output  1  block accepts a byte this cycle; a byte transfers when in_valid&&in_ready.
out_valid  output  1  out_data holds a forwarded payload byte; no backpressure.
out_data  output  8  forwarded payload byte.
out_last  output  1  with out_valid: final payload byte of the packet.
pkt_done  output  1  one-cycle pulse: packet verdict available.
pkt_good  output  1  valid with pkt_done: 1 = packet good.
pkt_err  output  2  valid with pkt_done: 0 none, 1 length, 2 checksum, 3 timeout.
good_cnt  output  CNT_W  saturating count of good packets.
bad_cnt  output  CNT_W  saturating count of bad packets.

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_ready=0 during reset, 1 on the first cycle after release. All other outputs 0, counters 0, internal length/xor/timer 0.
- FSM states: IDLE, PAYLOAD, CSUM, REPORT.
- IDLE: an accepted byte is L. If L==0 or L>MAX_LEN, go to REPORT with err=1. Otherwise latch remaining=L, xor=0 and go to PAYLOAD.
- PAYLOAD: each accepted byte updates xor^=byte and decrements remaining. The byte appears on out_data with out_valid the next cycle, which is 1-cycle registered latency. out_last is set for the byte that brings remaining to 0. When remaining reaches 0, go to CSUM.
- CSUM: an accepted byte is compared with xor. Equal: REPORT with err=0. Unequal: REPORT with err=2.
- REPORT: lasts exactly one cycle. in_ready=0. pkt_done=1 and pkt_good=(err==0), both registered outputs asserted during this cycle. The matching counter increments and holds at all-ones instead of wrapping. Next state is IDLE.
- Timeout: in PAYLOAD or CSUM, a timer counts cycles with no accepted byte and resets on every accepted byte. When the timer reaches TIMEOUT, go to REPORT with err=3. Bytes already forwarded are not retracted, and out_last is not issued for an aborted packet.
- in_ready=1 in IDLE, PAYLOAD and CSUM; 0 only in REPORT.
- No stall cycles inside a packet: back-to-back valid bytes are all accepted. Minimum packet spacing is one REPORT cycle.
- Reset asserted mid-packet: the partial packet is discarded and no pkt_done is issued for it.
- The checksum covers payload bytes only, not the length byte. The length byte is never forwarded.
- Exactly one pkt_done per framed packet. Counters only change in REPORT.

Decomposition:
- Shared package pkt_pkg: state_e enum (IDLE, PAYLOAD, CSUM, REPORT), err_e enum (ERR_NONE=0, ERR_LEN=1, ERR_CSUM=2, ERR_TMO=3), default constants for MAX_LEN and TIMEOUT.
- The same package holds the checksum function (XOR reduce), so the testbench Packet classes compute it identically.
- One natural sub-module: sat_counter (parameter CNT_W; inputs inc, clk, rst_n), instantiated twice for good_cnt and bad_cnt.

Test Plan:
1. L=3, payload 0x11,0x22,0x44, checksum 0x77, back-to-back -> out_data 0x11,0x22,0x44 one cycle after each transfer, out_last on 0x44. Then pkt_done with pkt_good=1, pkt_err=0, good_cnt=1.
2. Same packet with checksum 0x70 (bad packet) -> payload still forwarded. Then pkt_done, pkt_good=0, pkt_err=2, bad_cnt=1, good_cnt unchanged.
3. Length byte 0x00, then length byte 0x11 with MAX_LEN=16 -> each gives pkt_done on the REPORT cycle after that byte with pkt_err=1, no out_valid, bad_cnt=2.
4. L=2, send 0xAA, then drop in_valid for 8 cycles -> pkt_done with pkt_err=3 on the REPORT cycle after the timer reaches 8, no out_last, FSM back in IDLE. The next good packet passes.
5. 256 consecutive good L=1 packets with CNT_W=8 -> good_cnt saturates at 255. in_ready is low exactly one cycle after each checksum byte.
6. Assert rst_n low after 2 payload bytes of an L=4 packet -> all outputs 0 asynchronously, no pkt_done. A following good packet is checked correctly and good_cnt=1.
